uart_tx_buf: RTL and testbench

- Synthesizable UART transmitter, 8N1 format, with a built-in character FIFO.
- Serializes bytes written by the wave generator's response path onto txd.
- txd drives the board-level serial line, which the bench's UART receive model and response checker sample.
- Sits in the clk_tx domain, alongside the existing receive path.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx_buf.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Rounded clocks-per-oversample-tick; never below 1 so the divider always advances.
    function automatic int baud_div(input int clock_rate, input int baud_rate);
        longint den;
        longint quo;
        den = longint'(OVERSAMPLE) * longint'(baud_rate);
        if (den <= 64'sd0) begin
            quo = 64'sd1;
        end else begin
            quo = (longint'(clock_rate) + den / 64'sd2) / den;
        end
        if (quo < 64'sd1) begin
            quo = 64'sd1;
        end
        return int'(quo);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks while enabled.
// Held at zero while disabled so the first tick lands exactly DIV clocks
// after enable rises. Shared by the transmit and receive paths.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk_tx,
    input  logic rst_clk_tx_n,
    input  logic enable,
    output logic tick
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider counter; cleared on reset and whenever the consumer is idle
    always_ff @(posedge clk_tx) begin
        if (!rst_clk_tx_n) begin
            cnt_r <= '0;
        end else if (!enable) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Tick is a compare on the counter flop, qualified by enable
    assign tick = enable && (cnt_r == CNT_MAX);

endmodule

// File: rtl/uart_tx_buf.sv
// 8N1 UART transmitter with a character FIFO. Bytes handed over with a
// valid/ready handshake are queued and serialized LSB first onto txd.
// Consecutive queued bytes go out as contiguous frames with no idle gap.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_tx,
    input  logic                          rst_clk_tx_n,
    input  logic [7:0]                    char_data,
    input  logic                          char_valid,
    output logic                          char_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int             DIV        = baud_div(CLOCK_RATE, BAUD_RATE);
    localparam int             AW         = $clog2(FIFO_DEPTH);
    localparam int             LW         = AW + 1;
    localparam logic [LW-1:0]  LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [3:0]     OS_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]     BIT_LAST   = 3'(DATA_BITS - 1);

    // FIFO storage and bookkeeping
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    head_s;

    // Frame sequencer
    tx_state_t     state_r;
    logic [3:0]    os_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          txd_r;
    logic          busy_r;
    logic          baud_en_s;
    logic          tick_s;
    logic          bit_done_s;

    assign fifo_empty_s = (level_r == '0);
    assign fifo_full_s  = (level_r == LEVEL_FULL);
    assign head_s       = mem_r[rd_ptr_r];
    // Ready is not pop-aware: a full FIFO refuses even on a popping cycle
    assign push_s       = char_valid && !fifo_full_s;
    assign baud_en_s    = (state_r != IDLE);
    assign bit_done_s   = tick_s && (os_cnt_r == OS_LAST);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk_tx       (clk_tx),
        .rst_clk_tx_n (rst_clk_tx_n),
        .enable       (baud_en_s),
        .tick         (tick_s)
    );

    // Pop when idle with data waiting, or at the last tick of a stop bit with more queued
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = !fifo_empty_s;
            STOP:    pop_s = bit_done_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Character storage; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk_tx) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= char_data;
        end
    end

    // FIFO pointers (wrap modulo depth) and occupancy count
    always_ff @(posedge clk_tx) begin
        if (!rst_clk_tx_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame FSM; txd and tx_busy are registered from the current state
    always_ff @(posedge clk_tx) begin
        if (!rst_clk_tx_n) begin
            state_r   <= IDLE;
            os_cnt_r  <= 4'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE:    txd_r <= 1'b1;
                START:   txd_r <= 1'b0;
                DATA:    txd_r <= shift_r[0];
                STOP:    txd_r <= 1'b1;
                default: txd_r <= 1'b1;
            endcase
            busy_r <= (state_r != IDLE) || (level_r != '0);

            case (state_r)
                IDLE: begin
                    os_cnt_r <= 4'd0;
                    if (!fifo_empty_s) begin
                        shift_r   <= head_s;
                        bit_cnt_r <= 3'd0;
                        state_r   <= START;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        os_cnt_r <= 4'd0;
                        state_r  <= DATA;
                    end else if (tick_s) begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        os_cnt_r <= 4'd0;
                        shift_r  <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else if (tick_s) begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        os_cnt_r <= 4'd0;
                        if (!fifo_empty_s) begin
                            // Chain straight into the next frame; the baud divider keeps running
                            shift_r   <= head_s;
                            bit_cnt_r <= 3'd0;
                            state_r   <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (tick_s) begin
                        os_cnt_r <= os_cnt_r + 4'd1;
                    end
                end
                default: begin
                    os_cnt_r <= 4'd0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign char_ready = !fifo_full_s;
    assign txd        = txd_r;
    assign tx_busy    = busy_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: directed scenarios plus random bytes,
// with a UART receive model popping an expected-byte scoreboard.
module tb_uart_tx_buf;

    localparam int CLOCK_RATE = 1_600_000;
    localparam int BAUD_RATE  = 10_000;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT_CLKS   = CLOCK_RATE / BAUD_RATE;   // 160 clocks per bit
    localparam int FRAME_CLKS = 10 * BIT_CLKS;            // 1600 clocks per frame
    localparam int MID        = BIT_CLKS / 2;

    logic       clk_tx = 1'b0;
    logic       rst_clk_tx_n;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       txd;
    logic       tx_busy;
    logic [4:0] fifo_level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frames_rx = 0;
    logic [7:0] exp_q[$];

    // receive-model state
    bit         rx_active = 1'b0;
    int         rx_phase = 0;
    logic       rx_prev = 1'b1;
    logic [7:0] rx_byte = 8'd0;
    logic [7:0] rx_want;

    uart_tx_buf #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_tx       (clk_tx),
        .rst_clk_tx_n (rst_clk_tx_n),
        .char_data    (char_data),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .txd          (txd),
        .tx_busy      (tx_busy),
        .fifo_level   (fifo_level)
    );

    always #5 clk_tx = ~clk_tx;

    always @(posedge clk_tx) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // Present a byte until accepted; returns the edge number of acceptance
    task automatic write_byte(input logic [7:0] b, output int at);
        int   n;
        logic rdy;
        n = 0;
        at = -1;
        char_data  = b;
        char_valid = 1'b1;
        while (at < 0) begin
            rdy = char_ready;
            step();
            n++;
            if (rdy === 1'b1) begin
                at = cyc;
                exp_q.push_back(b);
            end else if (n > 4 * FRAME_CLKS) begin
                check("write accepted before timeout", rdy, 1);
                at = cyc;
            end
        end
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        step();
        step();
        while (tx_busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check("idle within budget", tx_busy, 0);
    endtask

    // Compare txd against the ideal 8N1 waveform of 'bytes', frames starting at edge n0+2
    task automatic check_wave(input string name, input int n0, input logic [7:0] bytes[$]);
        int         nb;
        int         bad;
        int         pos;
        logic       expv;
        logic [7:0] b;
        nb = bytes.size();
        for (int p = 0; p < 10 * nb; p++) begin
            b   = bytes[p / 10];
            pos = p % 10;
            if (pos == 0)      expv = 1'b0;
            else if (pos == 9) expv = 1'b1;
            else               expv = b[pos - 1];
            bad = 0;
            for (int k = 0; k < BIT_CLKS; k++) begin
                goto(n0 + 2 + p * BIT_CLKS + k);
                if (txd !== expv) bad++;
            end
            check($sformatf("%s bit period %0d wrong cycles", name, p), bad, 0);
        end
        goto(n0 + 1 + nb * FRAME_CLKS);
        check($sformatf("%s busy on last frame cycle", name), tx_busy, 1);
        step();
        check($sformatf("%s busy dropped", name), tx_busy, 0);
        check($sformatf("%s txd idle", name), txd, 1);
    endtask

    // UART receive model: samples mid-bit on the falling clock edge, checks against the scoreboard
    initial begin : monitor
        int idx;
        forever begin
            @(negedge clk_tx);
            if (rst_clk_tx_n !== 1'b1) begin
                rx_active = 1'b0;
                rx_prev   = 1'b1;
            end else if (!rx_active) begin
                if (rx_prev === 1'b1 && txd === 1'b0) begin
                    rx_active = 1'b1;
                    rx_phase  = 0;
                end
                rx_prev = txd;
            end else begin
                rx_phase++;
                if (rx_phase == MID) begin
                    check("rx start bit", txd, 0);
                end else if (rx_phase > MID && rx_phase < MID + 9 * BIT_CLKS &&
                             (rx_phase - MID) % BIT_CLKS == 0) begin
                    idx = (rx_phase - MID) / BIT_CLKS - 1;
                    rx_byte[idx] = txd;
                end else if (rx_phase == MID + 9 * BIT_CLKS) begin
                    check("rx stop bit", txd, 1);
                    frames_rx++;
                    check("rx frame had a pending byte", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        rx_want = exp_q.pop_front();
                        check("rx byte", rx_byte, rx_want);
                    end
                    rx_active = 1'b0;
                    rx_prev   = txd;
                end
            end
        end
    end

    initial begin : watchdog
        repeat (99_000) @(posedge clk_tx);
        $display("FAIL watchdog: bench did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         n0;
        int         n1;
        int         n2;
        int         fb;
        int         bad;
        int         at[17];
        logic [7:0] q[$];
        logic [7:0] rb;

        rst_clk_tx_n = 1'b0;
        char_valid   = 1'b0;
        char_data    = 8'd0;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset txd", txd, 1);
            check("reset busy", tx_busy, 0);
            check("reset ready", char_ready, 1);
            check("reset level", fifo_level, 0);
        end
        rst_clk_tx_n = 1'b1;
        repeat (3) step();

        // Single byte 0x55
        write_byte(8'h55, n0);
        check("single level after write", fifo_level, 1);
        step();
        check("single popped next edge", fifo_level, 0);
        check("single txd still high", txd, 1);
        check("single busy", tx_busy, 1);
        q = {8'h55};
        check_wave("single", n0, q);

        // Back-to-back "ABC"
        repeat (5) step();
        write_byte(8'h41, n0);
        write_byte(8'h42, n1);
        write_byte(8'h43, n2);
        check("b2b second accept edge", n1 - n0, 1);
        check("b2b third accept edge", n2 - n0, 2);
        q = {8'h41, 8'h42, 8'h43};
        check_wave("b2b", n0, q);

        // Full FIFO: 17 bytes without pause
        repeat (5) step();
        fb = frames_rx;
        for (int k = 0; k < 17; k++) begin
            rb = 8'(k);
            write_byte(rb, at[k]);
        end
        for (int k = 1; k < 17; k++) begin
            check($sformatf("full accept edge of byte %0d", k), at[k] - at[0], k);
        end
        check("full ready low", char_ready, 0);
        check("full level", fifo_level, 16);
        step();
        check("full ready still low", char_ready, 0);
        wait_idle(18 * FRAME_CLKS);
        check("full frames received", frames_rx - fb, 17);
        check("full scoreboard drained", exp_q.size(), 0);

        // Reset during data bit 3 of 0xA5 with 4 more queued
        repeat (5) step();
        write_byte(8'hA5, n0);
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom_range(0, 255));
            write_byte(rb, n1);
        end
        goto(n0 + 2 + 4 * BIT_CLKS + 40);
        check("midreset txd in bit 3", txd, 0);
        rst_clk_tx_n = 1'b0;
        step();
        check("midreset txd", txd, 1);
        check("midreset level", fifo_level, 0);
        check("midreset busy", tx_busy, 0);
        check("midreset ready", char_ready, 1);
        rst_clk_tx_n = 1'b1;
        exp_q.delete();
        fb  = frames_rx;
        bad = 0;
        for (int k = 0; k < 3 * FRAME_CLKS; k++) begin
            step();
            if (txd !== 1'b1) bad++;
        end
        check("midreset txd stays idle", bad, 0);
        check("midreset no frames", frames_rx - fb, 0);
        rb = 8'($urandom_range(0, 255));
        write_byte(rb, n0);
        wait_idle(2 * FRAME_CLKS);
        check("midreset one clean frame", frames_rx - fb, 1);
        check("midreset scoreboard drained", exp_q.size(), 0);

        // Write on the final stop-tick cycle while one byte is queued
        repeat (5) step();
        write_byte(8'h3C, n0);
        goto(n0 + 10);
        write_byte(8'hC3, n1);
        goto(n0 + FRAME_CLKS);
        check("overlap level before", fifo_level, 1);
        write_byte(8'h5A, n2);
        check("overlap accept edge", n2 - n0, FRAME_CLKS + 1);
        check("overlap level unchanged", fifo_level, 1);
        check("overlap stop bit still high", txd, 1);
        step();
        check("overlap next start immediate", txd, 0);
        wait_idle(4 * FRAME_CLKS);
        check("overlap scoreboard drained", exp_q.size(), 0);

        // Random bytes with random gaps
        fb = frames_rx;
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 300)) step();
            rb = 8'($urandom_range(0, 255));
            write_byte(rb, n0);
        end
        wait_idle(14 * FRAME_CLKS);
        check("random frames received", frames_rx - fb, 12);
        check("random scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
